// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blitter: width helper, FSM state encoding
// and the default transparency key.
package sprite_pkg;

  localparam int DEFAULT_TRANSPARENT = 0;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    DRAW,
    FLUSH,
    DONE
  } blitStateT;

  // Bits needed to index 'count' items; never less than one.
  function automatic int widthFor(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Command, ROM and VGA-adapter signals of the sprite blitter. The slave
// modport is the blitter itself; master is the controller/ROM/adapter side.
interface sprite_blitter_if #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int COLOUR_W = 3
);
  import sprite_pkg::*;

  localparam int XW  = widthFor(SCREEN_W);
  localparam int YW  = widthFor(SCREEN_H);
  localparam int AW  = widthFor(SCREEN_W * SCREEN_H);
  localparam int SAW = widthFor(SPRITE_W * SPRITE_H);

  logic                start;
  logic [XW-1:0]       old_x;
  logic [YW-1:0]       old_y;
  logic [XW-1:0]       new_x;
  logic [YW-1:0]       new_y;
  logic [SAW-1:0]      sprite_addr;
  logic [COLOUR_W-1:0] sprite_q;
  logic [AW-1:0]       bg_addr;
  logic [COLOUR_W-1:0] bg_q;
  logic                plot;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [COLOUR_W-1:0] colour;
  logic                busy;
  logic                done;

  modport master (
    output start, old_x, old_y, new_x, new_y, sprite_q, bg_q,
    input  sprite_addr, bg_addr, plot, x, y, colour, busy, done
  );

  modport slave (
    input  start, old_x, old_y, new_x, new_y, sprite_q, bg_q,
    output sprite_addr, bg_addr, plot, x, y, colour, busy, done
  );

endinterface

// File: rtl/sprite_scan_counter.sv
// Raster counter over one sprite footprint: dx runs fastest, dy outer,
// wrapping back to (0,0) after the last pixel so phases can run back to back.
module sprite_scan_counter
  import sprite_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  localparam int DXW   = widthFor(WIDTH),
  localparam int DYW   = widthFor(HEIGHT)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           enable,
  output logic [DXW-1:0] dx,
  output logic [DYW-1:0] dy,
  output logic           last
);

  logic rowEnd;
  logic colEnd;

  assign rowEnd = (dx == DXW'(WIDTH - 1));
  assign colEnd = (dy == DYW'(HEIGHT - 1));
  assign last   = rowEnd && colEnd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= '0;
      dy <= '0;
    end else if (enable) begin
      if (rowEnd) begin
        dx <= '0;
        dy <= colEnd ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Erases a sprite's old footprint from the background ROM, then draws it at
// its new position, through a two-stage address/data pixel pipeline.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int SPRITE_W    = 8,
  parameter int SPRITE_H    = 8,
  parameter int COLOUR_W    = 3,
  parameter int TRANSPARENT = DEFAULT_TRANSPARENT
) (
  input logic clock,
  input logic reset,
  sprite_blitter_if.slave bus
);

  localparam int XW  = widthFor(SCREEN_W);
  localparam int YW  = widthFor(SCREEN_H);
  localparam int AW  = widthFor(SCREEN_W * SCREEN_H);
  localparam int SAW = widthFor(SPRITE_W * SPRITE_H);
  localparam int DXW = widthFor(SPRITE_W);
  localparam int DYW = widthFor(SPRITE_H);

  blitStateT      state;
  blitStateT      nextState;
  logic           flushCount;
  logic [XW-1:0]  oldXReg;
  logic [YW-1:0]  oldYReg;
  logic [XW-1:0]  newXReg;
  logic [YW-1:0]  newYReg;
  logic           samePos;
  logic           counterClear;
  logic           counterEnable;
  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;
  logic           lastPixel;

  logic           issuing;
  logic           erasing;
  logic [XW:0]    px;
  logic [YW:0]    py;
  logic           clip;
  logic [AW-1:0]  bgAddrNext;

  logic           aValid;
  logic           aErase;
  logic           aClip;
  logic [XW-1:0]  aPx;
  logic [YW-1:0]  aPy;
  logic           dValid;
  logic           dErase;
  logic           dClip;
  logic [XW-1:0]  dPx;
  logic [YW-1:0]  dPy;

  sprite_scan_counter #(
    .WIDTH  (SPRITE_W),
    .HEIGHT (SPRITE_H)
  ) scanCounter (
    .clock  (clock),
    .reset  (reset),
    .clear  (counterClear),
    .enable (counterEnable),
    .dx     (dx),
    .dy     (dy),
    .last   (lastPixel)
  );

  assign samePos  = (bus.old_x == bus.new_x) && (bus.old_y == bus.new_y);
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  // State register; positions are captured only when a start is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      flushCount <= 1'b0;
      oldXReg    <= '0;
      oldYReg    <= '0;
      newXReg    <= '0;
      newYReg    <= '0;
    end else begin
      state      <= nextState;
      flushCount <= (state == FLUSH) && !flushCount;
      if (state == IDLE && bus.start) begin
        oldXReg <= bus.old_x;
        oldYReg <= bus.old_y;
        newXReg <= bus.new_x;
        newYReg <= bus.new_y;
      end
    end
  end

  always_comb begin
    nextState     = state;
    counterClear  = 1'b0;
    counterEnable = 1'b0;
    case (state)
      IDLE: begin
        counterClear = 1'b1;
        if (bus.start) nextState = samePos ? DRAW : ERASE;
      end
      ERASE: begin
        counterEnable = 1'b1;
        if (lastPixel) nextState = DRAW;
      end
      DRAW: begin
        counterEnable = 1'b1;
        if (lastPixel) nextState = FLUSH;
      end
      FLUSH: begin
        if (flushCount) nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Pixel coordinates carry one spare bit so off-screen pixels clip, not wrap.
  always_comb begin
    issuing    = (state == ERASE) || (state == DRAW);
    erasing    = (state == ERASE);
    px         = {1'b0, (erasing ? oldXReg : newXReg)} + (XW+1)'(dx);
    py         = {1'b0, (erasing ? oldYReg : newYReg)} + (YW+1)'(dy);
    clip       = (px >= (XW+1)'(SCREEN_W)) || (py >= (YW+1)'(SCREEN_H));
    bgAddrNext = clip ? '0 : (AW'(py) * AW'(SCREEN_W) + AW'(px));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aValid          <= 1'b0;
      aErase          <= 1'b0;
      aClip           <= 1'b0;
      aPx             <= '0;
      aPy             <= '0;
      bus.bg_addr     <= '0;
      bus.sprite_addr <= '0;
    end else begin
      aValid <= issuing;
      aErase <= erasing;
      if (issuing) begin
        aClip           <= clip;
        aPx             <= px[XW-1:0];
        aPy             <= py[YW-1:0];
        bus.bg_addr     <= bgAddrNext;
        bus.sprite_addr <= SAW'({dy, dx});
      end
    end
  end

  // ROM data arrives one cycle after its address, so the pixel tag is
  // delayed by a stage before the plot is registered against it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dValid     <= 1'b0;
      dErase     <= 1'b0;
      dClip      <= 1'b0;
      dPx        <= '0;
      dPy        <= '0;
      bus.plot   <= 1'b0;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
    end else begin
      dValid   <= aValid;
      dErase   <= aErase;
      dClip    <= aClip;
      dPx      <= aPx;
      dPy      <= aPy;
      bus.plot <= dValid && !dClip;
      if (dValid && !dClip) begin
        bus.x <= dPx;
        bus.y <= dPy;
        if (dErase || bus.sprite_q == COLOUR_W'(TRANSPARENT)) bus.colour <= bus.bg_q;
        else bus.colour <= bus.sprite_q;
      end
    end
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised successor to the fixed 8x8 rocket drawer.
- On a start pulse, erases a sprite's old footprint by restoring background pixels, then draws the sprite at its new position.
- Supports configurable screen and sprite sizes, transparency keying and screen-edge clipping, with a busy/done handshake.
- Sits between the game controller and the VGA adapter; it drives the adapter's plot/x/y/colour and reads two external synchronous ROMs (sprite and background).

Parameters:
- SCREEN_W, 320, screen width in pixels.
- SCREEN_H, 240, screen height in pixels.
- SPRITE_W, 8, sprite width; power of two, 2..32.
- SPRITE_H, 8, sprite height; power of two, 2..32.
- COLOUR_W, 3, colour bits per pixel.
- TRANSPARENT, 0, sprite colour value treated as see-through.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- old_x  in  XW=clog2(SCREEN_W)  previous top-left x.
- old_y  in  YW=clog2(SCREEN_H)  previous top-left y.
- new_x  in  XW  new top-left x.
- new_y  in  YW  new top-left y.
- sprite_addr  out  clog2(SPRITE_W*SPRITE_H)  sprite ROM address; row-major, dy*SPRITE_W+dx.
- sprite_q  in  COLOUR_W  sprite ROM data; 1-cycle read latency.
- bg_addr  out  clog2(SCREEN_W*SCREEN_H)  background ROM address, y*SCREEN_W+x.
- bg_q  in  COLOUR_W  background ROM data; 1-cycle read latency.
- plot  out  1  pixel write strobe to the VGA adapter.
- x  out  XW  pixel x.
- y  out  YW  pixel y.
- colour  out  COLOUR_W  pixel colour.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse when the operation completes.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; plot, busy, done, x, y, colour, sprite_addr and bg_addr all 0. The pipeline is flushed and no further plots are issued.
- start is ignored while busy=1, including during the done cycle. On acceptance, old_* and new_* are latched; later input changes have no effect.
- States: IDLE -> ERASE -> DRAW -> FLUSH -> DONE -> IDLE.
- ERASE is skipped (IDLE -> DRAW) when old_x==new_x and old_y==new_y.
- Scan order: counters dx (inner, 0..SPRITE_W-1) and dy (outer, 0..SPRITE_H-1). One pixel address is issued per cycle, so each phase takes exactly N=SPRITE_W*SPRITE_H cycles.
- Address stage (registered outputs):
  - px = base_x+dx and py = base_y+dy, computed one bit wider than XW/YW (no wrap).
  - base is old_* in ERASE and new_* in DRAW.
  - bg_addr = py*SCREEN_W+px; forced to 0 when clipped.
  - sprite_addr = dy*SPRITE_W+dx.
- A pixel is clipped when px>=SCREEN_W or py>=SCREEN_H.
- Data stage: one cycle after an address, ROM data is valid. On the next edge, plot/x/y/colour are registered from the pipelined px, py, phase and clip flag:
  - ERASE: colour=bg_q.
  - DRAW: colour = sprite_q unless sprite_q==TRANSPARENT, in which case colour=bg_q.
  - Clipped pixel: plot=0; x, y and colour hold their previous values.
- Latency: a pixel's plot is visible 2 cycles after its address is issued.
- FLUSH lasts 2 cycles to drain the pipeline. DONE lasts 1 cycle with done=1 and busy=1, then returns to IDLE.
- Total operation: 2N+3 cycles from the first address to done, or N+3 if ERASE is skipped.
- plot is 0 in every cycle that carries no valid, unclipped pixel.
- Arithmetic widths: py*SCREEN_W is computed as an unsigned constant multiply at bg_addr width.

Decomposition:
- Shared package (sprite_pkg): XW/YW/address-width functions (clog2), the state encoding (IDLE, ERASE, DRAW, FLUSH, DONE) and the default TRANSPARENT constant.
- One sub-module, sprite_scan_counter: the dx/dy raster counter with a last-pixel flag, reused by the erase and draw phases.
- The FSM and the 2-stage pixel pipeline stay in the top module.

Test Plan:
1. Reset check: assert reset mid-DRAW -> the next cycle has plot=0, busy=0, done=0. A later start begins cleanly with the first bg_addr from the new inputs.
2. Move (10,20)->(11,20) with 320x240, 8x8 defaults:
   - First bg_addr=6410.
   - 64 erase plots covering x 10..17, y 20..27 with colour=bg_q, then 64 draw plots covering x 11..18.
   - done exactly 131 cycles after the first address; busy falls the cycle after done.
3. old==new=(50,50) -> exactly 64 plots, all DRAW; done 67 cycles after the first address.
4. Clip: new=(316,236) -> exactly 16 plots (x 316..319, y 236..239); no plot with x>=320 or y>=240; timing unchanged (N+3).
5. Transparency: sprite ROM word 5 = 0, background = 3'b101 -> the pixel at (new_x+5, new_y) is plotted with colour 101; all other pixels use sprite_q.
6. Handshake: pulse start while busy and again in the done cycle -> both are ignored, and the plot count for the run is unchanged. A start one cycle after done is accepted.
